// File: rtl/ascon_stream_ctrl_pkg.sv
// Shared types, FSM states and word-arithmetic helpers for the Ascon stream controller.
// u64_t/u128_t match the core-side word and tag types.
package ascon_stream_ctrl_pkg;

  typedef logic [63:0]  u64_t;
  typedef logic [127:0] u128_t;

  // Widest size field the helpers accept; callers zero-extend into it.
  localparam int SIZE_MAX_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    INIT,
    AD,
    PT,
    FINAL,
    DONE
  } stream_state_e;

  function automatic logic [SIZE_MAX_W:0] size_to_words(input logic [SIZE_MAX_W-1:0] size);
    logic [SIZE_MAX_W:0] sum;
    sum = {1'b0, size} + (SIZE_MAX_W+1)'(7);
    return sum >> 3;
  endfunction

  function automatic logic [3:0] last_bytes(input logic [2:0] size_lsb);
    return (size_lsb == 3'd0) ? 4'd8 : {1'b0, size_lsb};
  endfunction

endpackage

// File: rtl/ascon_stream_ctrl_word_cnt.sv
// ascon_word_cnt: per-phase word counter, reloaded with the phase size and
// flagging the last word together with its valid byte count.
module ascon_word_cnt
  import ascon_stream_ctrl_pkg::*;
#(
  parameter int DATA_AW = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DATA_AW-1:0] size_i,
  input  logic               adv_i,
  output logic               last_o,
  output logic [3:0]         bytes_o
);

  logic [DATA_AW-1:0]  size_q, size_d;
  logic [DATA_AW:0]    cnt_q, cnt_d;
  logic [SIZE_MAX_W:0] words;
  logic [SIZE_MAX_W:0] cnt_ext;

  assign words   = size_to_words(SIZE_MAX_W'(size_q));
  assign cnt_ext = (SIZE_MAX_W+1)'(cnt_q);
  assign last_o  = (cnt_ext == words - (SIZE_MAX_W+1)'(1));
  assign bytes_o = last_o ? last_bytes(size_q[2:0]) : 4'd8;

  always_comb begin
    size_d = size_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      size_d = size_i;
      cnt_d  = '0;
    end else if (adv_i) begin
      cnt_d = cnt_q + (DATA_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      size_q <= '0;
      cnt_q  <= '0;
    end else begin
      size_q <= size_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/ascon_stream_ctrl.sv
// Job sequencer between the APB register block and the Ascon AEAD core.
// Optional cycle counter port cycle_cnt_o is enabled by ASCON_STREAM_CTRL_CYCLE_CNT_EN.
module ascon_stream_ctrl
  import ascon_stream_ctrl_pkg::*;
#(
  parameter int DATA_AW     = 7,
  parameter int DELAY_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [DATA_AW-1:0]     ad_size_i,
  input  logic [DATA_AW-1:0]     pt_size_i,
  input  logic [DELAY_WIDTH-1:0] delay_i,
  output logic                   ready_o,
  output logic                   wait_ad_o,
  output logic                   wait_pt_o,
  output logic                   tag_valid_o,
  output logic [127:0]           tag_o,
  output logic                   ad_pop_o,
  input  logic [63:0]            ad_i,
  input  logic                   ad_empty_i,
  output logic                   pt_pop_o,
  input  logic [63:0]            pt_i,
  input  logic                   pt_empty_i,
  output logic                   ct_push_o,
  output logic [63:0]            ct_o,
  input  logic                   ct_full_i,
  output logic                   core_start_o,
  input  logic                   core_ready_i,
  output logic                   core_valid_o,
  input  logic                   core_ready_in_i,
  output logic                   core_type_o,
  output logic [63:0]            core_data_o,
  output logic                   core_last_o,
  output logic [3:0]             core_bytes_o,
  input  logic                   core_ct_valid_i,
  input  logic [63:0]            core_ct_i,
  output logic                   core_ct_ready_o,
  input  logic                   core_tag_valid_i,
  input  logic [127:0]           core_tag_i
`ifdef ASCON_STREAM_CTRL_CYCLE_CNT_EN
  ,
  output logic [31:0]            cycle_cnt_o
`endif
);

  stream_state_e          state_q;
  logic                   start_q;
  logic [DATA_AW-1:0]     ad_size_q, pt_size_q;
  logic [DELAY_WIDTH-1:0] delay_q, dly_cnt_q;
  logic                   core_start_q;
  logic                   tag_valid_q;
  u128_t                  tag_q;

  logic               start_edge, idle, in_ad, in_pt, accept, ad_has, pt_has;
  logic               wc_load, wc_adv, wc_last;
  logic [DATA_AW-1:0] wc_size;
  logic [3:0]         wc_bytes;

  assign idle       = (state_q == IDLE) || (state_q == DONE);
  assign start_edge = start_i && !start_q;
  assign in_ad      = (state_q == AD);
  assign in_pt      = (state_q == PT);
  assign ad_has     = (ad_size_q != '0);
  assign pt_has     = (pt_size_q != '0);

  // Handshakes are gated by rst_n so a reset cycle never pops or pushes a FIFO.
  assign core_valid_o    = rst_n && ((in_ad && !ad_empty_i) || (in_pt && !pt_empty_i));
  assign accept          = core_valid_o && core_ready_in_i;
  assign ad_pop_o        = accept && in_ad;
  assign pt_pop_o        = accept && in_pt;
  assign core_type_o     = in_pt;
  assign core_data_o     = in_ad ? ad_i : (in_pt ? pt_i : 64'h0);
  assign core_last_o     = (in_ad || in_pt) && wc_last;
  assign core_bytes_o    = (in_ad || in_pt) ? wc_bytes : 4'd0;
  assign core_ct_ready_o = rst_n && !ct_full_i;
  assign ct_push_o       = core_ct_valid_i && core_ct_ready_o;
  assign ct_o            = core_ct_i;
  assign core_start_o    = core_start_q;

  assign ready_o     = idle;
  assign wait_ad_o   = in_ad && ad_empty_i;
  assign wait_pt_o   = in_pt && pt_empty_i;
  assign tag_valid_o = tag_valid_q;
  assign tag_o       = tag_q;

  always_comb begin
    wc_load = 1'b0;
    wc_adv  = 1'b0;
    wc_size = ad_size_q;
    case (state_q)
      INIT: begin
        if (core_ready_i && ad_has) begin
          wc_load = 1'b1;
        end else if (core_ready_i && pt_has) begin
          wc_load = 1'b1;
          wc_size = pt_size_q;
        end
      end
      AD: begin
        if (accept && wc_last) begin
          wc_load = pt_has;
          wc_size = pt_size_q;
        end else begin
          wc_adv = accept;
        end
      end
      PT:      wc_adv = accept && !wc_last;
      default: wc_adv = 1'b0;
    endcase
  end

  ascon_word_cnt #(
    .DATA_AW (DATA_AW)
  ) u_word_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (wc_load),
    .size_i  (wc_size),
    .adv_i   (wc_adv),
    .last_o  (wc_last),
    .bytes_o (wc_bytes)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      ad_size_q    <= '0;
      pt_size_q    <= '0;
      delay_q      <= '0;
      dly_cnt_q    <= '0;
      core_start_q <= 1'b0;
      tag_valid_q  <= 1'b0;
      tag_q        <= '0;
    end else begin
      start_q      <= start_i;
      core_start_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            ad_size_q   <= ad_size_i;
            pt_size_q   <= pt_size_i;
            delay_q     <= delay_i;
            dly_cnt_q   <= DELAY_WIDTH'(1);
            tag_valid_q <= 1'b0;
            // A zero delay spends no cycle in DELAY.
            state_q     <= (delay_i == '0) ? INIT : DELAY;
          end
        end
        DELAY: begin
          if (dly_cnt_q >= delay_q) begin
            state_q <= INIT;
          end else begin
            dly_cnt_q <= dly_cnt_q + DELAY_WIDTH'(1);
          end
        end
        INIT: begin
          if (core_ready_i) begin
            core_start_q <= 1'b1;
            state_q      <= ad_has ? AD : (pt_has ? PT : FINAL);
          end
        end
        AD: begin
          if (accept && wc_last) begin
            state_q <= pt_has ? PT : FINAL;
          end
        end
        PT: begin
          if (accept && wc_last) begin
            state_q <= FINAL;
          end
        end
        FINAL: begin
          if (core_tag_valid_i) begin
            tag_q       <= core_tag_i;
            tag_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ASCON_STREAM_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
    end else if (idle && start_edge) begin
      cycle_cnt_q <= '0;
    end else if ((state_q inside {INIT, AD, PT, FINAL}) && (cycle_cnt_q != '1)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_ascon_stream_ctrl.sv
// Self-checking bench for ascon_stream_ctrl: directed jobs plus randomized FIFO/core
// behaviour, checked against a word-stream model derived from the job sizes.
`timescale 1ns/1ps
module tb_ascon_stream_ctrl;

  localparam int DATA_AW     = 7;
  localparam int DELAY_WIDTH = 16;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   start_i;
  logic [DATA_AW-1:0]     ad_size_i, pt_size_i;
  logic [DELAY_WIDTH-1:0] delay_i;
  logic                   ready_o, wait_ad_o, wait_pt_o, tag_valid_o;
  logic [127:0]           tag_o;
  logic                   ad_pop_o, ad_empty_i, pt_pop_o, pt_empty_i;
  logic [63:0]            ad_i, pt_i, ct_o, core_data_o, core_ct_i;
  logic                   ct_push_o, ct_full_i;
  logic                   core_start_o, core_ready_i, core_valid_o, core_ready_in_i;
  logic                   core_type_o, core_last_o;
  logic [3:0]             core_bytes_o;
  logic                   core_ct_valid_i, core_ct_ready_o, core_tag_valid_i;
  logic [127:0]           core_tag_i;
`ifdef ASCON_STREAM_CTRL_CYCLE_CNT_EN
  logic [31:0]            cycle_cnt_o;
`endif

  int           testCount = 0;
  int           failCount = 0;
  logic         tagValidModel = 1'b0;
  logic [127:0] lastTag = '0;

  ascon_stream_ctrl #(
    .DATA_AW     (DATA_AW),
    .DELAY_WIDTH (DELAY_WIDTH)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .ad_size_i        (ad_size_i),
    .pt_size_i        (pt_size_i),
    .delay_i          (delay_i),
    .ready_o          (ready_o),
    .wait_ad_o        (wait_ad_o),
    .wait_pt_o        (wait_pt_o),
    .tag_valid_o      (tag_valid_o),
    .tag_o            (tag_o),
    .ad_pop_o         (ad_pop_o),
    .ad_i             (ad_i),
    .ad_empty_i       (ad_empty_i),
    .pt_pop_o         (pt_pop_o),
    .pt_i             (pt_i),
    .pt_empty_i       (pt_empty_i),
    .ct_push_o        (ct_push_o),
    .ct_o             (ct_o),
    .ct_full_i        (ct_full_i),
    .core_start_o     (core_start_o),
    .core_ready_i     (core_ready_i),
    .core_valid_o     (core_valid_o),
    .core_ready_in_i  (core_ready_in_i),
    .core_type_o      (core_type_o),
    .core_data_o      (core_data_o),
    .core_last_o      (core_last_o),
    .core_bytes_o     (core_bytes_o),
    .core_ct_valid_i  (core_ct_valid_i),
    .core_ct_i        (core_ct_i),
    .core_ct_ready_o  (core_ct_ready_o),
    .core_tag_valid_i (core_tag_valid_i),
    .core_tag_i       (core_tag_i)
`ifdef ASCON_STREAM_CTRL_CYCLE_CNT_EN
    ,
    .cycle_cnt_o      (cycle_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, 128'(obs), 128'(exp));
  endtask

  task automatic applyStimulus();
    ad_i             = '0;
    ad_empty_i       = 1'b1;
    pt_i             = '0;
    pt_empty_i       = 1'b1;
    ct_full_i        = 1'b0;
    core_ready_i     = 1'b1;
    core_ready_in_i  = 1'b0;
    core_ct_valid_i  = 1'b0;
    core_ct_i        = '0;
    core_tag_valid_i = 1'b0;
    core_tag_i       = '0;
  endtask

  // One job: start edge, expected core_start latency, word stream, tag capture.
  // abortAt >= 0 pulses reset once that many PT words have been accepted.
  task automatic runJob(input int adSize, input int ptSize, input int dly, input int adHold,
                        input bit randIn, input int abortAt);
    int          adWords = (adSize + 7) / 8;
    int          ptWords = (ptSize + 7) / 8;
    logic [63:0] adQ[$];
    logic [63:0] ptQ[$];
    int          adAcc = 0;
    int          ptAcc = 0;
    int          cycles = 0;
    int          holdLeft = adHold;
    int          finalWait;
    int          idx, words, sz;
    bit          startSeen = 0, tagSent = 0, tagNow = 0, finished = 0;
    bit          expStart, inAd, inPt, expValid, acc, isLast;
    logic [3:0]  expBytes;
    logic [63:0] expData;
    logic [127:0] expTag = '0;

    for (int i = 0; i < adWords; i++) adQ.push_back({$urandom, $urandom});
    for (int i = 0; i < ptWords; i++) ptQ.push_back({$urandom, $urandom});
    finalWait = int'($urandom_range(0, 3));

    @(posedge clk); #1;
    ad_size_i = DATA_AW'(adSize);
    pt_size_i = DATA_AW'(ptSize);
    delay_i   = DELAY_WIDTH'(dly);
    start_i   = 1'b1;

    while (!finished && cycles < dly + 400) begin
      if (startSeen && holdLeft > 0) holdLeft--;
      if (core_tag_valid_i) begin
        core_tag_valid_i = 1'b0;
        tagNow = 1'b1;
      end else if (startSeen && adAcc == adWords && ptAcc == ptWords && !tagSent) begin
        if (finalWait == 0) begin
          expTag = {$urandom, $urandom, $urandom, $urandom};
          core_tag_i = expTag;
          core_tag_valid_i = 1'b1;
          tagSent = 1'b1;
        end else begin
          finalWait--;
        end
      end
      ad_empty_i = (adQ.size() == 0) || (holdLeft > 0) || (randIn && $urandom_range(0, 3) == 0);
      ad_i       = (adQ.size() > 0) ? adQ[0] : 64'h0;
      pt_empty_i = (ptQ.size() == 0) || (randIn && $urandom_range(0, 3) == 0);
      pt_i       = (ptQ.size() > 0) ? ptQ[0] : 64'h0;
      core_ready_in_i = randIn ? ($urandom_range(0, 3) != 0) : 1'b1;

      @(negedge clk);
      cycles++;
      if (tagNow) begin
        checkBit("ready_done", ready_o, 1'b1);
        checkBit("tag_valid_done", tag_valid_o, 1'b1);
        checkOutput("tag_value", tag_o, expTag);
        tagValidModel = 1'b1;
        lastTag = expTag;
        finished = 1'b1;
      end else begin
        expStart = !startSeen && (cycles == dly + 3);
        checkBit("core_start", core_start_o, expStart);
        if (expStart) startSeen = 1'b1;
        checkBit("ready_busy", ready_o, cycles == 1);
        checkBit("tag_valid_busy", tag_valid_o, (cycles == 1) ? tagValidModel : 1'b0);
        inAd = startSeen && adAcc < adWords;
        inPt = startSeen && adAcc == adWords && ptAcc < ptWords;
        if (abortAt >= 0 && inPt && ptAcc >= abortAt && ptQ.size() > 0) begin
          core_ready_in_i = 1'b1;
          pt_empty_i = 1'b0;
          rst_n = 1'b0;
          #1;
          checkOutput("abort_pop", 128'({ad_pop_o, pt_pop_o}), 128'(2'b00));
          checkBit("abort_valid", core_valid_o, 1'b0);
          @(posedge clk); #1;
          rst_n = 1'b1;
          start_i = 1'b0;
          applyStimulus();
          @(negedge clk);
          checkBit("abort_ready", ready_o, 1'b1);
          checkBit("abort_tag_valid", tag_valid_o, 1'b0);
          checkBit("abort_idle_valid", core_valid_o, 1'b0);
          tagValidModel = 1'b0;
          return;
        end
        expValid = (inAd && !ad_empty_i) || (inPt && !pt_empty_i);
        checkBit("core_valid", core_valid_o, expValid);
        checkBit("wait_ad", wait_ad_o, inAd && ad_empty_i);
        checkBit("wait_pt", wait_pt_o, inPt && pt_empty_i);
        acc = expValid && core_ready_in_i;
        checkOutput("pops", 128'({ad_pop_o, pt_pop_o}), 128'({acc && inAd, acc && inPt}));
        if (acc) begin
          idx      = inAd ? adAcc : ptAcc;
          words    = inAd ? adWords : ptWords;
          sz       = inAd ? adSize : ptSize;
          isLast   = (idx == words - 1);
          expBytes = !isLast ? 4'd8 : ((sz % 8 == 0) ? 4'd8 : 4'(sz % 8));
          expData  = inAd ? adQ[0] : ptQ[0];
          checkBit("core_type", core_type_o, inPt);
          checkOutput("core_data", 128'(core_data_o), 128'(expData));
          checkBit("core_last", core_last_o, isLast);
          checkOutput("core_bytes", 128'(core_bytes_o), 128'(expBytes));
          if (inAd) begin
            void'(adQ.pop_front());
            adAcc++;
          end else begin
            void'(ptQ.pop_front());
            ptAcc++;
          end
        end
      end
      @(posedge clk); #1;
    end

    checkBit("job_done", finished, 1'b1);
    start_i = 1'b0;
    applyStimulus();
    if (!finished) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      tagValidModel = 1'b0;
    end
  endtask

  // CT backpressure: full FIFO holds the word back, push happens when full drops.
  task automatic ctTest();
    logic [63:0] w = {$urandom, $urandom};
    core_ct_i       = w;
    core_ct_valid_i = 1'b1;
    ct_full_i       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkBit("ct_push_full", ct_push_o, 1'b0);
      checkBit("ct_ready_full", core_ct_ready_o, 1'b0);
      @(posedge clk); #1;
    end
    ct_full_i = 1'b0;
    @(negedge clk);
    checkBit("ct_push_free", ct_push_o, 1'b1);
    checkBit("ct_ready_free", core_ct_ready_o, 1'b1);
    checkOutput("ct_data", 128'(ct_o), 128'(w));
    @(posedge clk); #1;
    core_ct_valid_i = 1'b0;
    @(negedge clk);
    checkBit("ct_push_idle", ct_push_o, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] strayTag;
    rst_n     = 1'b0;
    start_i   = 1'b0;
    ad_size_i = '0;
    pt_size_i = '0;
    delay_i   = '0;
    applyStimulus();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkBit("rst_ct_ready", core_ct_ready_o, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkBit("rst_ready", ready_o, 1'b1);
    checkBit("rst_wait_ad", wait_ad_o, 1'b0);
    checkBit("rst_wait_pt", wait_pt_o, 1'b0);
    checkBit("rst_tag_valid", tag_valid_o, 1'b0);
    checkOutput("rst_tag", tag_o, 128'h0);
    checkOutput("rst_pops", 128'({ad_pop_o, pt_pop_o, ct_push_o}), 128'(3'b000));
    checkBit("rst_core_start", core_start_o, 1'b0);
    checkBit("rst_core_valid", core_valid_o, 1'b0);
    checkBit("rst_core_last", core_last_o, 1'b0);
    checkOutput("rst_core_bytes", 128'(core_bytes_o), 128'(4'd0));

    runJob(16, 16, 0, 0, 1'b0, -1);

    // A tag strobe outside FINAL must not disturb the captured tag.
    @(posedge clk); #1;
    strayTag = {$urandom, $urandom, $urandom, $urandom};
    core_tag_i = strayTag;
    core_tag_valid_i = 1'b1;
    @(posedge clk); #1;
    core_tag_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("tag_hold", tag_o, lastTag);
    checkBit("tag_valid_hold", tag_valid_o, 1'b1);

    runJob(0, 5, 0, 0, 1'b0, -1);
    runJob(40, 13, 10, 0, 1'b0, -1);
    runJob(24, 8, 3, 20, 1'b0, -1);
    ctTest();
    runJob(8, 64, 0, 0, 1'b0, 2);
    runJob(16, 16, 0, 0, 1'b0, -1);
    runJob(0, 0, 0, 0, 1'b0, -1);
    runJob(127, 127, 1, 0, 1'b1, -1);
    for (int j = 0; j < 8; j++) begin
      runJob(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
             int'($urandom_range(0, 5)), 0, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
